// File: rtl/uart_flow_pkg.sv
// uart_flow_pkg
// Shared types and constants for the multi-channel UART flow-control block.
//   rts_state_e      : per-channel RTS state (DISABLED, OPEN, THROTTLED)
//   THROTTLE_W       : width of each saturating throttle counter
//   DEFAULT_HIGH_WM  : default RX level at/above which RTS is deasserted
//   DEFAULT_LOW_WM   : default RX level at/below which RTS is reasserted
package uart_flow_pkg;

  typedef enum logic [1:0] {
    RTS_DISABLED  = 2'd0,
    RTS_OPEN      = 2'd1,
    RTS_THROTTLED = 2'd2
  } rts_state_e;

  localparam int THROTTLE_W      = 16;
  localparam int DEFAULT_HIGH_WM = 48;
  localparam int DEFAULT_LOW_WM  = 16;

endpackage

// File: rtl/uart_cts_filter.sv
// uart_cts_filter
// One channel of CTS conditioning: a multi-flop synchroniser followed by a
// debounce filter that only accepts a new CTS level once it has been seen
// for FILTER consecutive synchronised samples.
// Ports:
//   clk    in  : system clock
//   rst    in  : synchronous active-high reset
//   cts_n  in  : asynchronous Clear-to-Send, active low
//   cts_ok out : filtered CTS, high when the far end permits transmission
module uart_cts_filter
  import uart_flow_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cts_n,
  output logic cts_ok
);

  // Counter only needs to reach FILTER-1; keep at least one bit for FILTER=1.
  localparam int CNT_W = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER - 1);

  generate
    if (SYNC_STAGES < 2 || FILTER < 1) begin : g_param_check
      $error("uart_cts_filter: SYNC_STAGES must be >= 2 and FILTER >= 1");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced_n;
  logic                   accepted_n_q;
  logic [CNT_W-1:0]       cnt_q;

  assign synced_n = sync_q[SYNC_STAGES-1];

  // Synchroniser preset to the idle (deasserted) level so reset never looks
  // like a CTS edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cts_n};
    end
  end

  // Any sample matching the accepted level restarts the run, so only an
  // uninterrupted run of FILTER differing samples flips the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      accepted_n_q <= 1'b1;
      cnt_q        <= '0;
    end else if (synced_n == accepted_n_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      accepted_n_q <= synced_n;
      cnt_q        <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cts_ok = ~accepted_n_q;

endmodule

// File: rtl/uart_flow_ctrl_mc.sv
// uart_flow_ctrl_mc
// Multi-channel hardware flow control and heartbeat LED. Per channel it runs
// an RTS state machine with watermark hysteresis, filters CTS into a TX
// permit and counts throttled cycles.
// Ports:
//   clk          in  : system clock
//   rst          in  : synchronous active-high reset
//   rx_level     in  : RX FIFO occupancy per channel
//   rx_full      in  : RX FIFO full per channel
//   ch_enable    in  : bridge enable per channel
//   uart_cts_n   in  : asynchronous Clear-to-Send per channel, active low
//   err_present  in  : any bridge reports an error (speeds up the LED)
//   stats_clear  in  : single-cycle pulse clearing all throttle counters
//   uart_rts_n   out : Request-to-Send per channel, active low, registered
//   tx_allow     out : TX engine may start a new byte, registered
//   throttle_cnt out : saturating count of THROTTLED cycles per channel
//   led          out : heartbeat LED, registered
module uart_flow_ctrl_mc
  import uart_flow_pkg::*;
#(
  parameter int NUM_CH          = 1,
  parameter int LEVEL_W         = 7,
  parameter int HIGH_WM         = DEFAULT_HIGH_WM,
  parameter int LOW_WM          = DEFAULT_LOW_WM,
  parameter int CTS_SYNC_STAGES = 2,
  parameter int CTS_FILTER      = 4,
  parameter int HB_DIV_W        = 26
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CH-1:0][LEVEL_W-1:0]       rx_level,
  input  logic [NUM_CH-1:0]                    rx_full,
  input  logic [NUM_CH-1:0]                    ch_enable,
  input  logic [NUM_CH-1:0]                    uart_cts_n,
  input  logic                                 err_present,
  input  logic                                 stats_clear,
  output logic [NUM_CH-1:0]                    uart_rts_n,
  output logic [NUM_CH-1:0]                    tx_allow,
  output logic [NUM_CH-1:0][THROTTLE_W-1:0]    throttle_cnt,
  output logic                                 led
);

  localparam logic [LEVEL_W-1:0]    HIGH_LVL     = LEVEL_W'(HIGH_WM);
  localparam logic [LEVEL_W-1:0]    LOW_LVL      = LEVEL_W'(LOW_WM);
  localparam logic [THROTTLE_W-1:0] THROTTLE_MAX = '1;

  generate
    if (NUM_CH < 1 || LOW_WM >= HIGH_WM || HIGH_WM > (2**LEVEL_W) - 1 ||
        CTS_SYNC_STAGES < 2 || CTS_FILTER < 1 || HB_DIV_W < 4) begin : g_param_check
      $error("uart_flow_ctrl_mc: illegal parameter combination");
    end
  endgenerate

  genvar ch;
  generate
    for (ch = 0; ch < NUM_CH; ch++) begin : g_ch
      rts_state_e            state_q;
      rts_state_e            state_d;
      logic                  rts_n_q;
      logic                  tx_allow_q;
      logic                  cts_ok;
      logic [THROTTLE_W-1:0] thr_q;

      // Disable overrides everything; rx_full is checked alongside the level
      // so a full FIFO keeps the channel throttled even at a low level.
      always_comb begin
        state_d = state_q;
        if (!ch_enable[ch]) begin
          state_d = RTS_DISABLED;
        end else begin
          unique case (state_q)
            RTS_DISABLED:
              state_d = (rx_level[ch] < HIGH_LVL && !rx_full[ch]) ? RTS_OPEN : RTS_THROTTLED;
            RTS_OPEN:
              if (rx_level[ch] >= HIGH_LVL || rx_full[ch]) state_d = RTS_THROTTLED;
            RTS_THROTTLED:
              if (rx_level[ch] <= LOW_LVL && !rx_full[ch]) state_d = RTS_OPEN;
            default:
              state_d = RTS_DISABLED;
          endcase
        end
      end

      // RTS is registered from the state register, giving two cycles from
      // an input change to the pin.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= RTS_DISABLED;
          rts_n_q <= 1'b1;
        end else begin
          state_q <= state_d;
          rts_n_q <= (state_q != RTS_OPEN);
        end
      end

      uart_cts_filter #(
        .SYNC_STAGES (CTS_SYNC_STAGES),
        .FILTER      (CTS_FILTER)
      ) u_cts_filter (
        .clk    (clk),
        .rst    (rst),
        .cts_n  (uart_cts_n[ch]),
        .cts_ok (cts_ok)
      );

      always_ff @(posedge clk) begin
        if (rst) begin
          tx_allow_q <= 1'b0;
        end else begin
          tx_allow_q <= cts_ok & ch_enable[ch];
        end
      end

      // Clear wins over increment; the count sticks at all-ones.
      always_ff @(posedge clk) begin
        if (rst || stats_clear) begin
          thr_q <= '0;
        end else if (state_q == RTS_THROTTLED && thr_q != THROTTLE_MAX) begin
          thr_q <= thr_q + 1'b1;
        end
      end

      assign uart_rts_n[ch]   = rts_n_q;
      assign tx_allow[ch]     = tx_allow_q;
      assign throttle_cnt[ch] = thr_q;
    end
  endgenerate

  logic [HB_DIV_W-1:0] hb_cnt_q;

  // Error mode taps a bit two places lower for a 4x faster blink without
  // disturbing the free-running counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hb_cnt_q <= '0;
      led      <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_q + 1'b1;
      led      <= err_present ? hb_cnt_q[HB_DIV_W-3] : hb_cnt_q[HB_DIV_W-1];
    end
  end

endmodule

// File: tb/tb_uart_flow_ctrl_mc.sv
module tb_uart_flow_ctrl_mc;

  localparam int NUM_CH  = 3;
  localparam int LEVEL_W = 7;
  localparam int HIGH_WM = 48;
  localparam int LOW_WM  = 16;
  localparam int SYNC    = 2;
  localparam int FILT    = 4;
  localparam int HB_W    = 6;
  localparam int HW      = SYNC + FILT;

  logic                           clk = 1'b0;
  logic                           rst;
  logic [NUM_CH-1:0][LEVEL_W-1:0] rx_level;
  logic [NUM_CH-1:0]              rx_full;
  logic [NUM_CH-1:0]              ch_enable;
  logic [NUM_CH-1:0]              uart_cts_n;
  logic                           err_present;
  logic                           stats_clear;
  logic [NUM_CH-1:0]              uart_rts_n;
  logic [NUM_CH-1:0]              tx_allow;
  logic [NUM_CH-1:0][15:0]        throttle_cnt;
  logic                           led;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_flow_ctrl_mc #(
    .NUM_CH          (NUM_CH),
    .LEVEL_W         (LEVEL_W),
    .HIGH_WM         (HIGH_WM),
    .LOW_WM          (LOW_WM),
    .CTS_SYNC_STAGES (SYNC),
    .CTS_FILTER      (FILT),
    .HB_DIV_W        (HB_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_level     (rx_level),
    .rx_full      (rx_full),
    .ch_enable    (ch_enable),
    .uart_cts_n   (uart_cts_n),
    .err_present  (err_present),
    .stats_clear  (stats_clear),
    .uart_rts_n   (uart_rts_n),
    .tx_allow     (tx_allow),
    .throttle_cnt (throttle_cnt),
    .led          (led)
  );

  // Reference model: "on" = channel enabled since last edge, "open" = gate
  // open under the watermark rules; CTS accepted when the last FILT samples
  // seen through the synchroniser all disagree with the accepted level.
  logic [NUM_CH-1:0] m_on, m_open, m_rts_n, m_tx, m_acc_n;
  logic [HW-1:0]     m_hist [NUM_CH];
  int                m_thr  [NUM_CH];
  int                m_cyc;
  logic              m_led;

  always @(posedge clk) begin
    if (rst) begin
      m_on    <= '0;
      m_open  <= '0;
      m_rts_n <= '1;
      m_tx    <= '0;
      m_acc_n <= '1;
      m_cyc   <= 0;
      m_led   <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        m_hist[ch] <= '1;
        m_thr[ch]  <= 0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        m_rts_n[ch] <= ~(m_on[ch] & m_open[ch]);
        if (!ch_enable[ch]) begin
          m_on[ch]   <= 1'b0;
          m_open[ch] <= 1'b0;
        end else if (!m_on[ch]) begin
          m_on[ch]   <= 1'b1;
          m_open[ch] <= (int'(rx_level[ch]) < HIGH_WM) && !rx_full[ch];
        end else if (m_open[ch]) begin
          m_open[ch] <= !((int'(rx_level[ch]) >= HIGH_WM) || rx_full[ch]);
        end else begin
          m_open[ch] <= (int'(rx_level[ch]) <= LOW_WM) && !rx_full[ch];
        end

        if (stats_clear) m_thr[ch] <= 0;
        else if (m_on[ch] && !m_open[ch] && m_thr[ch] < 65535) m_thr[ch] <= m_thr[ch] + 1;

        m_hist[ch] <= {m_hist[ch][HW-2:0], uart_cts_n[ch]};
        if (m_hist[ch][SYNC-1 +: FILT] == {FILT{~m_acc_n[ch]}}) m_acc_n[ch] <= ~m_acc_n[ch];
        m_tx[ch] <= ~m_acc_n[ch] & ch_enable[ch];
      end
      m_led <= (((m_cyc % 64) / (err_present ? 8 : 32)) % 2) == 1;
      m_cyc <= m_cyc + 1;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      checkVal($sformatf("rts_n[%0d]", ch), 32'(uart_rts_n[ch]), 32'(m_rts_n[ch]));
      checkVal($sformatf("tx_allow[%0d]", ch), 32'(tx_allow[ch]), 32'(m_tx[ch]));
      checkVal($sformatf("throttle_cnt[%0d]", ch), 32'(throttle_cnt[ch]), m_thr[ch]);
    end
    checkVal("led", 32'(led), 32'(m_led));
  endtask

  task automatic applyStimulus(input int cycles, input bit check);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (check) checkOutput();
    end
  endtask

  int   lvl [NUM_CH];
  int   t_first, t_second;
  logic prev_led;

  initial begin
    rst         = 1'b1;
    rx_level    = '0;
    rx_full     = '0;
    ch_enable   = '0;
    uart_cts_n  = '1;
    err_present = 1'b0;
    stats_clear = 1'b0;
    $display("[TB] reset");
    applyStimulus(3, 1'b0);
    checkVal("reset_rts_n", 32'(uart_rts_n), 32'h7);
    checkVal("reset_tx_allow", 32'(tx_allow), 32'h0);
    checkVal("reset_thr0", 32'(throttle_cnt[0]), 32'h0);
    checkVal("reset_led", 32'(led), 32'h0);
    rst = 1'b0;

    $display("[TB] enable channel 0");
    ch_enable[0] = 1'b1;
    applyStimulus(1, 1'b1);
    checkVal("en_rts_d1", 32'(uart_rts_n[0]), 32'h1);
    applyStimulus(1, 1'b1);
    checkVal("en_rts_d2", 32'(uart_rts_n[0]), 32'h0);
    checkVal("en_tx_cts_high", 32'(tx_allow[0]), 32'h0);

    $display("[TB] CTS glitch");
    uart_cts_n[0] = 1'b0;
    applyStimulus(3, 1'b1);
    uart_cts_n[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1'b1);
      checkVal("glitch_tx", 32'(tx_allow[0]), 32'h0);
    end

    $display("[TB] CTS steady low latency");
    uart_cts_n[0] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1, 1'b1);
      checkVal($sformatf("cts_lat_%0d", i), 32'(tx_allow[0]), 32'(i == 7));
    end

    $display("[TB] hysteresis ramp");
    for (int l = 1; l <= 50; l++) begin
      rx_level[0] = 7'(l);
      applyStimulus(1, 1'b1);
      checkVal("ramp_up_rts", 32'(uart_rts_n[0]), 32'((l - 1) >= HIGH_WM));
    end
    applyStimulus(3, 1'b1);
    for (int l = 49; l >= 10; l--) begin
      rx_level[0] = 7'(l);
      applyStimulus(1, 1'b1);
      checkVal("ramp_down_rts", 32'(uart_rts_n[0]), 32'((l + 1) > LOW_WM));
    end
    checkVal("hyst_thr", 32'(throttle_cnt[0]), 32'd39);

    $display("[TB] full wins over low level");
    rx_level[0] = 7'd5;
    rx_full[0]  = 1'b1;
    applyStimulus(4, 1'b1);
    checkVal("full_wins", 32'(uart_rts_n[0]), 32'h1);
    rx_full[0] = 1'b0;
    applyStimulus(2, 1'b1);
    checkVal("full_release", 32'(uart_rts_n[0]), 32'h0);

    $display("[TB] enable drop");
    checkVal("tx_pre_disable", 32'(tx_allow[0]), 32'h1);
    ch_enable[0] = 1'b0;
    applyStimulus(1, 1'b1);
    checkVal("dis_tx_d1", 32'(tx_allow[0]), 32'h0);
    checkVal("dis_rts_d1", 32'(uart_rts_n[0]), 32'h0);
    applyStimulus(1, 1'b1);
    checkVal("dis_rts_d2", 32'(uart_rts_n[0]), 32'h1);

    $display("[TB] heartbeat periods");
    prev_led = led; t_first = -1; t_second = -1;
    for (int c = 1; c <= 80 && t_second < 0; c++) begin
      applyStimulus(1, 1'b1);
      if (led !== prev_led) begin
        if (t_first < 0) t_first = c; else t_second = c;
        prev_led = led;
      end
    end
    checkVal("hb_period_normal", 32'(t_second - t_first), 32'd32);
    err_present = 1'b1;
    applyStimulus(2, 1'b1);
    prev_led = led; t_first = -1; t_second = -1;
    for (int c = 1; c <= 30 && t_second < 0; c++) begin
      applyStimulus(1, 1'b1);
      if (led !== prev_led) begin
        if (t_first < 0) t_first = c; else t_second = c;
        prev_led = led;
      end
    end
    checkVal("hb_period_err", 32'(t_second - t_first), 32'd8);
    err_present = 1'b0;

    $display("[TB] throttle saturation and clear");
    ch_enable  = 3'b010;
    rx_full[1] = 1'b1;
    applyStimulus(70000, 1'b0);
    applyStimulus(1, 1'b1);
    checkVal("thr_saturated", 32'(throttle_cnt[1]), 32'hFFFF);
    stats_clear = 1'b1;
    applyStimulus(1, 1'b1);
    checkVal("thr_clear", 32'(throttle_cnt[1]), 32'h0);
    stats_clear = 1'b0;
    applyStimulus(1, 1'b1);
    checkVal("thr_after_clear", 32'(throttle_cnt[1]), 32'h1);

    $display("[TB] randomized multi-channel traffic");
    ch_enable = '1;
    rx_full   = '0;
    for (int ch = 0; ch < NUM_CH; ch++) lvl[ch] = 32;
    for (int c = 0; c < 600; c++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        lvl[ch] = lvl[ch] + int'($urandom_range(0, 12)) - 6;
        if (lvl[ch] < 0)  lvl[ch] = 0;
        if (lvl[ch] > 64) lvl[ch] = 64;
        rx_level[ch] = 7'(lvl[ch]);
        rx_full[ch]  = (lvl[ch] == 64) || ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 63) == 0) ch_enable[ch] = ~ch_enable[ch];
        if ($urandom_range(0, 7) == 0) uart_cts_n[ch] = ~uart_cts_n[ch];
      end
      if ($urandom_range(0, 99) < 5) err_present = ~err_present;
      stats_clear = ($urandom_range(0, 63) == 0);
      applyStimulus(1, 1'b1);
    end
    stats_clear = 1'b0;

    $display("[TB] independent channels");
    ch_enable   = '1;
    rx_full     = '0;
    rx_level[0] = 7'd0;
    rx_level[1] = 7'd0;
    rx_level[2] = 7'd60;
    applyStimulus(3, 1'b1);
    checkVal("indep_rts_a", 32'(uart_rts_n), 32'h4);
    rx_level[1] = 7'd50;
    applyStimulus(2, 1'b1);
    checkVal("indep_rts_b", 32'(uart_rts_n), 32'h6);

    $display("[TB] reset mid-operation");
    rst = 1'b1;
    applyStimulus(1, 1'b1);
    checkVal("midrst_rts_n", 32'(uart_rts_n), 32'h7);
    checkVal("midrst_tx", 32'(tx_allow), 32'h0);
    checkVal("midrst_thr1", 32'(throttle_cnt[1]), 32'h0);
    checkVal("midrst_thr2", 32'(throttle_cnt[2]), 32'h0);
    checkVal("midrst_led", 32'(led), 32'h0);
    rst = 1'b0;
    applyStimulus(10, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
